// File: rtl/downstream_cancel_sequencer.sv
// Round-robin arbiter that serialises saturating read-modify-write updates
// to the per-client cancelled-total RAM, one update every four cycles.
module downstream_cancel_sequencer #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_client,
    input  logic [NUM_REQ*DATA_W-1:0] req_amount,
    output logic [ADDR_W-1:0]         ram_rd_addr,
    input  logic [DATA_W-1:0]         ram_rd_data,
    output logic                      ram_wr_en,
    output logic [ADDR_W-1:0]         ram_wr_addr,
    output logic [DATA_W-1:0]         ram_wr_data,
    output logic                      done_valid,
    output logic [2:0]                done_src,
    output logic [ADDR_W-1:0]         done_client,
    output logic [DATA_W-1:0]         done_total,
    output logic                      done_sat,
    output logic                      busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        ADD,
        WR
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   client_q;
    logic [DATA_W-1:0]   amount_q;
    logic [2:0]          src_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [2:0]          dsrc_q;
    logic [ADDR_W-1:0]   dclient_q;
    logic [DATA_W-1:0]   dtotal_q;
    logic                dsat_q;

    logic [NUM_REQ-1:0]  gnt;
    logic                gnt_found;
    int unsigned         gnt_idx;
    int unsigned         scan_idx;
    logic [DATA_W:0]     sum;
    logic                sum_sat;
    logic [DATA_W-1:0]   sum_res;

    // Scan from rr_ptr upward (wrapping) and grant the first valid feed.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        gnt_idx   = 0;
        scan_idx  = 0;
        if (state_q == IDLE) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
                if (!gnt_found && req_valid[scan_idx]) begin
                    gnt_found     = 1'b1;
                    gnt[scan_idx] = 1'b1;
                    gnt_idx       = scan_idx;
                end
            end
        end
    end

    assign sum     = {1'b0, ram_rd_data} + {1'b0, amount_q};
    assign sum_sat = sum[DATA_W];
    assign sum_res = sum_sat ? '1 : sum[DATA_W-1:0];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    state_d  = RD;
                    rr_ptr_d = PTR_W'((gnt_idx + 1) % NUM_REQ);
                end
            end
            RD:      state_d = ADD;
            ADD:     state_d = WR;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            client_q  <= '0;
            amount_q  <= '0;
            src_q     <= '0;
            rd_addr_q <= '0;
            dsrc_q    <= '0;
            dclient_q <= '0;
            dtotal_q  <= '0;
            dsat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (state_q == IDLE && gnt_found) begin
                src_q     <= 3'(gnt_idx);
                client_q  <= req_client[gnt_idx*ADDR_W +: ADDR_W];
                amount_q  <= req_amount[gnt_idx*DATA_W +: DATA_W];
                rd_addr_q <= req_client[gnt_idx*ADDR_W +: ADDR_W];
            end
            // done_* registers double as the write port and hold after the pulse.
            if (state_q == ADD) begin
                dsrc_q    <= src_q;
                dclient_q <= client_q;
                dtotal_q  <= sum_res;
                dsat_q    <= sum_sat;
            end
        end
    end

    // Reset forces IDLE, so gating with rst_n keeps req_ready low during reset.
    assign req_ready   = rst_n ? gnt : '0;
    assign ram_rd_addr = rd_addr_q;
    assign ram_wr_en   = (state_q == WR);
    assign ram_wr_addr = dclient_q;
    assign ram_wr_data = dtotal_q;
    assign done_valid  = (state_q == WR);
    assign done_src    = dsrc_q;
    assign done_client = dclient_q;
    assign done_total  = dtotal_q;
    assign done_sat    = dsat_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_downstream_cancel_sequencer.sv
// Bench for downstream_cancel_sequencer: queue-fed requesters, a behavioural
// RAM, and a transaction-level model predicting grants and saturating totals.
module tb_downstream_cancel_sequencer;

    localparam int unsigned NR = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_client = '0;
    logic [NR*DW-1:0]  req_amount = '0;
    logic [AW-1:0]     ram_rd_addr;
    logic [DW-1:0]     ram_rd_data;
    logic              ram_wr_en;
    logic [AW-1:0]     ram_wr_addr;
    logic [DW-1:0]     ram_wr_data;
    logic              done_valid;
    logic [2:0]        done_src;
    logic [AW-1:0]     done_client;
    logic [DW-1:0]     done_total;
    logic              done_sat;
    logic              busy;

    downstream_cancel_sequencer #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_client(req_client), .req_amount(req_amount),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .done_valid(done_valid), .done_src(done_src), .done_client(done_client),
        .done_total(done_total), .done_sat(done_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous-read RAM; preload port used only while the DUT is idle.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pl_clr = 1'b0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        ram_rd_data <= ram[ram_rd_addr];
        if (pl_clr) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
        end else if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (ram_wr_en) begin
            ram[ram_wr_addr] <= ram_wr_data;
        end
    end

    typedef struct packed {
        logic [AW-1:0] c;
        logic [DW-1:0] a;
    } req_t;

    req_t fq0[$];
    req_t fq1[$];
    int   grant_log[$];

    // Transaction-level model state
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    int            m_phase;
    int            m_rr;
    int            m_src;
    logic [AW-1:0] m_client;
    logic [DW-1:0] m_amount;
    logic [AW-1:0] m_rd;
    int            l_src;
    logic [AW-1:0] l_client;
    logic [DW-1:0] l_total;
    logic          l_sat;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_rr = 0; m_rd = '0;
        l_src = 0; l_client = '0; l_total = '0; l_sat = 1'b0;
    endtask

    task automatic drive();
        req_valid[0] = (fq0.size() != 0);
        req_valid[1] = (fq1.size() != 0);
        if (fq0.size() != 0) begin
            req_client[AW-1:0] = fq0[0].c;
            req_amount[DW-1:0] = fq0[0].a;
        end
        if (fq1.size() != 0) begin
            req_client[2*AW-1:AW] = fq1[0].c;
            req_amount[2*DW-1:DW] = fq1[0].a;
        end
    endtask

    // One clock cycle: drive at negedge, check 1 time unit later, advance model.
    task automatic step();
        logic [NR-1:0] exp_rdy;
        logic [DW:0]   s;
        bit            v [NR];
        int            g;
        req_t          r;
        drive();
        #1;
        if (!rst_n) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_wr_en", 64'(ram_wr_en), 64'd0);
            chk("rst_done_valid", 64'(done_valid), 64'd0);
            chk("rst_rd_addr", 64'(ram_rd_addr), 64'd0);
            chk("rst_wr_addr", 64'(ram_wr_addr), 64'd0);
            chk("rst_wr_data", 64'(ram_wr_data), 64'd0);
            chk("rst_done_total", 64'(done_total), 64'd0);
            chk("rst_done_misc", {58'd0, done_src, done_sat, done_client[1:0]}, 64'd0);
            chk("rst_done_client", 64'(done_client), 64'd0);
            model_reset();
        end else begin
            v[0] = (fq0.size() != 0);
            v[1] = (fq1.size() != 0);
            g = -1;
            if (m_phase == 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (g < 0 && v[(m_rr + k) % NR]) g = (m_rr + k) % NR;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("ram_wr_en", 64'(ram_wr_en), 64'(m_phase == 3));
            chk("done_valid", 64'(done_valid), 64'(m_phase == 3));
            if (m_phase == 3) begin
                s = 33'(m_mem[m_client]) + 33'(m_amount);
                l_sat = s[DW];
                l_total = s[DW] ? 32'hFFFF_FFFF : s[DW-1:0];
                l_src = m_src;
                l_client = m_client;
                m_mem[m_client] = l_total;
                chk("ram_wr_addr", 64'(ram_wr_addr), 64'(m_client));
                chk("ram_wr_data", 64'(ram_wr_data), 64'(l_total));
            end
            if (m_phase != 0) chk("ram_rd_addr", 64'(ram_rd_addr), 64'(m_rd));
            chk("done_src", 64'(done_src), 64'(l_src));
            chk("done_client", 64'(done_client), 64'(l_client));
            chk("done_total", 64'(done_total), 64'(l_total));
            chk("done_sat", 64'(done_sat), 64'(l_sat));
            case (m_phase)
                0: if (g >= 0) begin
                    if (g == 0) r = fq0.pop_front();
                    else        r = fq1.pop_front();
                    m_src = g; m_client = r.c; m_amount = r.a; m_rd = r.c;
                    m_rr = (g + 1) % NR;
                    m_phase = 1;
                    grant_log.push_back(g);
                end
                1: m_phase = 2;
                2: m_phase = 3;
                default: m_phase = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int max_cycles);
        int n = 0;
        while ((fq0.size() != 0 || fq1.size() != 0 || m_phase != 0) && n < max_cycles) begin
            step();
            n++;
        end
        chk("run_bound", 64'(n < max_cycles), 64'd1);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        m_mem[a] = d;
    endtask

    initial begin
        int n;
        int gl;
        model_reset();
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
        rst_n = 1'b0;
        pl_clr = 1'b1;
        @(negedge clk);
        pl_clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single update
        fq0.push_back('{c: 5'd3, a: 32'd10});
        run_idle(20);
        chk("first_total", 64'(done_total), 64'd10);
        chk("first_src", 64'(done_src), 64'd0);
        chk("ram3_after_first", 64'(ram[3]), 64'd10);

        // Back-to-back to the same client
        fq0.push_back('{c: 5'd3, a: 32'd5});
        fq0.push_back('{c: 5'd3, a: 32'd7});
        run_idle(30);
        chk("ram3_after_two", 64'(ram[3]), 64'd22);
        chk("total_22", 64'(done_total), 64'd22);

        // Contention: grants must alternate
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            fq0.push_back('{c: 5'd1, a: 32'd1});
            fq1.push_back('{c: 5'd2, a: 32'd1});
        end
        run_idle(60);
        chk("grant_count", 64'(grant_log.size()), 64'd8);
        for (int i = 1; i < grant_log.size(); i++)
            chk("grant_alternates", 64'(grant_log[i] != grant_log[i-1]), 64'd1);
        chk("ram1_total", 64'(ram[1]), 64'd4);
        chk("ram2_total", 64'(ram[2]), 64'd4);

        // Saturation, then a zero amount at the ceiling
        preload(5'd7, 32'hFFFF_FFF0);
        fq0.push_back('{c: 5'd7, a: 32'h20});
        run_idle(20);
        chk("sat_total", 64'(done_total), 64'hFFFF_FFFF);
        chk("sat_flag", 64'(done_sat), 64'd1);
        fq0.push_back('{c: 5'd7, a: 32'd0});
        run_idle(20);
        chk("zero_amt_total", 64'(done_total), 64'hFFFF_FFFF);
        chk("zero_amt_sat", 64'(done_sat), 64'd0);

        // Reset in the ADD cycle aborts the update
        fq0.push_back('{c: 5'd9, a: 32'd4});
        n = 0;
        while (m_phase != 2 && n < 10) begin
            step();
            n++;
        end
        chk("reach_add_bound", 64'(n < 10), 64'd1);
        rst_n = 1'b0;
        step();
        fq1.push_back('{c: 5'd12, a: 32'd6});
        step();
        chk("no_write_client9", 64'(ram[9]), 64'd0);
        rst_n = 1'b1;
        grant_log.delete();
        run_idle(20);
        gl = (grant_log.size() != 0) ? grant_log[0] : -1;
        chk("post_reset_grant", 64'(gl), 64'd1);
        chk("post_reset_src", 64'(done_src), 64'd1);
        chk("ram12_total", 64'(ram[12]), 64'd6);
        chk("ram9_still_zero", 64'(ram[9]), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 40; i++) begin
            req_t r;
            r.c = 5'($urandom_range(0, 5));
            r.a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 500));
            if ($urandom_range(0, 1) == 0) fq0.push_back(r);
            else                           fq1.push_back(r);
        end
        run_idle(400);
        for (int i = 0; i < (1 << AW); i++)
            chk("ram_final", 64'(ram[i]), 64'(m_mem[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
